// File: rtl/race_ctrl_pkg.sv
// Shared types and constants for the race controller slice.
package race_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    RACING    = 3'd2,
    FINISHED  = 3'd3,
    TIMEOUT   = 3'd4
  } race_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_TIE  = 2'b11
  } winner_e;

  localparam int unsigned BCD_W = 8;

endpackage

// File: rtl/race_ctrl_if.sv
// Signal bundle between the race controller and its surroundings
// (user switch, rate divider, display counter, finish sensors, HEX/LED outputs).
interface race_ctrl_if;
  import race_pkg::*;

  logic             start;
  logic             tick_1hz;
  logic [3:0]       time_ones;
  logic [3:0]       time_tens;
  logic             p1_finish;
  logic             p2_finish;
  logic             count_enable;
  logic             count_clear_n;
  logic [3:0]       countdown_val;
  logic [2:0]       state;
  logic [1:0]       winner;
  logic [BCD_W-1:0] p1_time;
  logic [BCD_W-1:0] p2_time;
  logic             done;

  modport master (
    output start, tick_1hz, time_ones, time_tens, p1_finish, p2_finish,
    input  count_enable, count_clear_n, countdown_val, state, winner,
           p1_time, p2_time, done
  );

  modport slave (
    input  start, tick_1hz, time_ones, time_tens, p1_finish, p2_finish,
    output count_enable, count_clear_n, countdown_val, state, winner,
           p1_time, p2_time, done
  );

endinterface

// File: rtl/race_ctrl_rise_detect.sv
// Rising-edge detector: registers the previous level and flags a 0->1 change.
module rise_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sig_q <= 1'b0;
    else          sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/race_ctrl.sv
// Race game controller: start countdown, gates the seconds counter, latches
// finish times, decides the winner and detects timeout.
module race_ctrl
  import race_pkg::*;
#(
  parameter logic [3:0]       COUNTDOWN_SECS = 4'd3,
  parameter logic [BCD_W-1:0] TIME_LIMIT_BCD = 8'h99
) (
  input logic         clock,
  input logic         reset_n,
  race_ctrl_if.slave  bus
);

  race_state_e      state_q, state_d;
  logic [3:0]       cd_q, cd_d;
  winner_e          win_q, win_d;
  logic [BCD_W-1:0] p1_time_q, p1_time_d;
  logic [BCD_W-1:0] p2_time_q, p2_time_d;
  logic             p1_done_q, p1_done_d;
  logic             p2_done_q, p2_done_d;
  logic             start_rise;
  logic [BCD_W-1:0] race_time;
  logic             p1_new, p2_new;

  rise_detect u_start_rise (
    .clock   (clock),
    .reset_n (reset_n),
    .sig     (bus.start),
    .rise    (start_rise)
  );

  assign race_time = {bus.time_tens, bus.time_ones};
  assign p1_new    = bus.p1_finish & ~p1_done_q;
  assign p2_new    = bus.p2_finish & ~p2_done_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cd_q      <= '0;
      win_q     <= WIN_NONE;
      p1_time_q <= '0;
      p2_time_q <= '0;
      p1_done_q <= 1'b0;
      p2_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cd_q      <= cd_d;
      win_q     <= win_d;
      p1_time_q <= p1_time_d;
      p2_time_q <= p2_time_d;
      p1_done_q <= p1_done_d;
      p2_done_q <= p2_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cd_d      = cd_q;
    win_d     = win_q;
    p1_time_d = p1_time_q;
    p2_time_d = p2_time_q;
    p1_done_d = p1_done_q;
    p2_done_d = p2_done_q;

    unique case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d   = COUNTDOWN;
          cd_d      = COUNTDOWN_SECS;
          win_d     = WIN_NONE;
          p1_time_d = '0;
          p2_time_d = '0;
          p1_done_d = 1'b0;
          p2_done_d = 1'b0;
        end
      end

      COUNTDOWN: begin
        if (bus.tick_1hz) begin
          if (cd_q <= 4'd1) begin
            state_d = RACING;
            cd_d    = '0;
          end else begin
            cd_d = cd_q - 4'd1;
          end
        end
      end

      RACING: begin
        if (p1_new) begin
          p1_time_d = race_time;
          p1_done_d = 1'b1;
        end
        if (p2_new) begin
          p2_time_d = race_time;
          p2_done_d = 1'b1;
        end
        if (win_q == WIN_NONE) begin
          if (p1_new && p2_new) win_d = WIN_TIE;
          else if (p1_new)      win_d = WIN_P1;
          else if (p2_new)      win_d = WIN_P2;
        end
        // Finishes in this cycle take priority over a coincident timeout tick.
        if (p1_done_d && p2_done_d) begin
          state_d = FINISHED;
        end else if (bus.tick_1hz && race_time == TIME_LIMIT_BCD) begin
          state_d = TIMEOUT;
          if (!p1_done_d) p1_time_d = TIME_LIMIT_BCD;
          if (!p2_done_d) p2_time_d = TIME_LIMIT_BCD;
        end
      end

      FINISHED, TIMEOUT: begin
        if (start_rise) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.count_clear_n = (state_q == RACING) || (state_q == FINISHED) ||
                             (state_q == TIMEOUT);
  assign bus.count_enable  = (state_q == RACING) & bus.tick_1hz;
  assign bus.done          = (state_q == FINISHED) || (state_q == TIMEOUT);
  assign bus.countdown_val = cd_q;
  assign bus.state         = state_q;
  assign bus.winner        = win_q;
  assign bus.p1_time       = p1_time_q;
  assign bus.p2_time       = p2_time_q;

endmodule

// File: tb/tb_race_ctrl.sv
// Bench for race_ctrl: two instances (default limit and 8'h10 limit) share stimulus.
module tb_race_ctrl;
  import race_pkg::*;

  typedef struct {
    bit         rst;
    int         sel;
    logic       start;
    logic       tick;
    logic [7:0] t;
    logic       p1;
    logic       p2;
    logic [2:0] st;
    logic [3:0] cd;
    logic [1:0] win;
    logic [7:0] p1t;
    logic [7:0] p2t;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, tick = 1'b0, p1 = 1'b0, p2 = 1'b0;
  logic [7:0] t = 8'h00;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t sb[$];
  vec_t tbl[$];

  always #5 clock = ~clock;

  race_ctrl_if ifa ();
  race_ctrl_if ifb ();

  assign ifa.start = start;  assign ifb.start = start;
  assign ifa.tick_1hz = tick;  assign ifb.tick_1hz = tick;
  assign ifa.time_tens = t[7:4];  assign ifb.time_tens = t[7:4];
  assign ifa.time_ones = t[3:0];  assign ifb.time_ones = t[3:0];
  assign ifa.p1_finish = p1;  assign ifb.p1_finish = p1;
  assign ifa.p2_finish = p2;  assign ifb.p2_finish = p2;

  race_ctrl #(.COUNTDOWN_SECS(4'd3), .TIME_LIMIT_BCD(8'h99)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(ifa.slave));
  race_ctrl #(.COUNTDOWN_SECS(4'd3), .TIME_LIMIT_BCD(8'h10)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(ifb.slave));

  function automatic vec_t mk(bit rst, int sel, bit s, bit tk, logic [7:0] tm,
                              bit a, bit b, int st, int cd, int win,
                              logic [7:0] p1t, logic [7:0] p2t);
    vec_t v;
    v.rst = rst; v.sel = sel; v.start = s; v.tick = tk; v.t = tm;
    v.p1 = a; v.p2 = b; v.st = 3'(st); v.cd = 4'(cd); v.win = 2'(win);
    v.p1t = p1t; v.p2t = p2t;
    return v;
  endfunction

  task automatic chk(input string tag, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec%0d: got %0h want %0h", tag, idx, act, exp);
    end
  endtask

  task automatic compare(input vec_t e, input int idx);
    logic [2:0] st;  logic [3:0] cd;  logic [1:0] win;
    logic [7:0] p1t, p2t;  logic dn, ce, ccn;
    logic e_dn, e_ce, e_ccn;
    if (e.sel == 0) begin
      st = ifa.state; cd = ifa.countdown_val; win = ifa.winner;
      p1t = ifa.p1_time; p2t = ifa.p2_time; dn = ifa.done;
      ce = ifa.count_enable; ccn = ifa.count_clear_n;
    end else begin
      st = ifb.state; cd = ifb.countdown_val; win = ifb.winner;
      p1t = ifb.p1_time; p2t = ifb.p2_time; dn = ifb.done;
      ce = ifb.count_enable; ccn = ifb.count_clear_n;
    end
    e_dn  = (e.st == 3'd3) || (e.st == 3'd4);
    e_ccn = (e.st == 3'd2) || e_dn;
    e_ce  = (e.st == 3'd2) && e.tick;
    n_vec++;
    chk("state", idx, 8'(st), 8'(e.st));
    chk("countdown_val", idx, 8'(cd), 8'(e.cd));
    chk("winner", idx, 8'(win), 8'(e.win));
    chk("p1_time", idx, p1t, e.p1t);
    chk("p2_time", idx, p2t, e.p2t);
    chk("done", idx, 8'(dn), 8'(e_dn));
    chk("count_enable", idx, 8'(ce), 8'(e_ce));
    chk("count_clear_n", idx, 8'(ccn), 8'(e_ccn));
  endtask

  task automatic zero_inputs();
    start = 1'b0; tick = 1'b0; t = 8'h00; p1 = 1'b0; p2 = 1'b0;
  endtask

  task automatic do_reset(input int idx);
    vec_t r;
    @(negedge clock);
    zero_inputs();
    reset_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      r = mk(0, s, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      sb.push_back(r);
    end
    while (sb.size() > 0) compare(sb.pop_front(), idx);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clock);
    start = v.start; tick = v.tick; t = v.t; p1 = v.p1; p2 = v.p2;
    sb.push_back(v);
    @(posedge clock);
    #1;
    compare(sb.pop_front(), idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    // countdown, first-finisher win, duplicate finish, hold after FINISHED
    tbl.push_back(mk(1,0, 1,0,8'h00,0,0, 1,3,0,8'h00,8'h00));
    tbl.push_back(mk(0,0, 1,1,8'h00,0,0, 1,2,0,8'h00,8'h00));
    tbl.push_back(mk(0,0, 1,1,8'h00,0,0, 1,1,0,8'h00,8'h00));
    tbl.push_back(mk(0,0, 1,1,8'h00,0,0, 2,0,0,8'h00,8'h00));
    tbl.push_back(mk(0,0, 1,0,8'h12,1,0, 2,0,1,8'h12,8'h00));
    tbl.push_back(mk(0,0, 1,0,8'h13,1,0, 2,0,1,8'h12,8'h00));
    tbl.push_back(mk(0,0, 1,0,8'h15,0,1, 3,0,1,8'h12,8'h15));
    tbl.push_back(mk(0,0, 1,1,8'h15,0,0, 3,0,1,8'h12,8'h15));
    tbl.push_back(mk(0,0, 0,0,8'h15,0,0, 3,0,1,8'h12,8'h15));
    tbl.push_back(mk(0,0, 1,0,8'h15,0,0, 0,0,1,8'h12,8'h15));
    // restart, false start ignored, same-cycle tie
    tbl.push_back(mk(0,0, 0,0,8'h00,0,0, 0,0,1,8'h12,8'h15));
    tbl.push_back(mk(0,0, 1,0,8'h00,0,0, 1,3,0,8'h00,8'h00));
    tbl.push_back(mk(0,0, 1,0,8'h05,1,0, 1,3,0,8'h00,8'h00));
    tbl.push_back(mk(0,0, 1,1,8'h00,0,0, 1,2,0,8'h00,8'h00));
    tbl.push_back(mk(0,0, 1,1,8'h00,0,0, 1,1,0,8'h00,8'h00));
    tbl.push_back(mk(0,0, 1,1,8'h00,0,0, 2,0,0,8'h00,8'h00));
    tbl.push_back(mk(0,0, 1,0,8'h07,1,1, 3,0,3,8'h07,8'h07));
    // timeout on the 8'h10-limit instance
    tbl.push_back(mk(1,1, 1,0,8'h00,0,0, 1,3,0,8'h00,8'h00));
    tbl.push_back(mk(0,1, 1,1,8'h00,0,0, 1,2,0,8'h00,8'h00));
    tbl.push_back(mk(0,1, 1,1,8'h00,0,0, 1,1,0,8'h00,8'h00));
    tbl.push_back(mk(0,1, 1,1,8'h00,0,0, 2,0,0,8'h00,8'h00));
    tbl.push_back(mk(0,1, 1,0,8'h04,0,1, 2,0,2,8'h00,8'h04));
    tbl.push_back(mk(0,1, 1,0,8'h06,0,1, 2,0,2,8'h00,8'h04));
    tbl.push_back(mk(0,1, 1,1,8'h09,0,0, 2,0,2,8'h00,8'h04));
    tbl.push_back(mk(0,1, 1,1,8'h10,0,0, 4,0,2,8'h10,8'h04));
    // finish coincident with timeout tick wins over timeout
    tbl.push_back(mk(1,1, 1,0,8'h00,0,0, 1,3,0,8'h00,8'h00));
    tbl.push_back(mk(0,1, 1,1,8'h00,0,0, 1,2,0,8'h00,8'h00));
    tbl.push_back(mk(0,1, 1,1,8'h00,0,0, 1,1,0,8'h00,8'h00));
    tbl.push_back(mk(0,1, 1,1,8'h00,0,0, 2,0,0,8'h00,8'h00));
    tbl.push_back(mk(0,1, 1,0,8'h05,1,0, 2,0,1,8'h05,8'h00));
    tbl.push_back(mk(0,1, 1,1,8'h10,0,1, 3,0,1,8'h05,8'h10));
    // race in progress, ahead of the asynchronous reset below
    tbl.push_back(mk(1,0, 1,0,8'h00,0,0, 1,3,0,8'h00,8'h00));
    tbl.push_back(mk(0,0, 1,1,8'h00,0,0, 1,2,0,8'h00,8'h00));
    tbl.push_back(mk(0,0, 1,1,8'h00,0,0, 1,1,0,8'h00,8'h00));
    tbl.push_back(mk(0,0, 1,1,8'h00,0,0, 2,0,0,8'h00,8'h00));
    tbl.push_back(mk(0,0, 1,0,8'h03,1,0, 2,0,1,8'h03,8'h00));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset(i);
      apply(tbl[i], i);
    end

    // reset asserted between clock edges must clear outputs at once
    @(negedge clock);
    zero_inputs();
    #2;
    reset_n = 1'b0;
    #1;
    v = mk(0,0, 0,0,8'h00,0,0, 0,0,0,8'h00,8'h00);
    sb.push_back(v);
    compare(sb.pop_front(), 100);
    @(negedge clock);
    reset_n = 1'b1;
    apply(mk(0,0, 0,0,8'h00,0,0, 0,0,0,8'h00,8'h00), 101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/race_ctrl.md
Name: race_ctrl

Overview:
- Game-control FSM sitting directly upstream of the seconds counter (rate divider + two-digit BCD display counter).
- Runs a start countdown, then gates the counter's 1 Hz enable and drives its clear.
- Consumes the counter's BCD time to latch each player's finish time, declare a winner and detect timeout.

Parameters:
COUNTDOWN_SECS, 3, pre-race countdown length in seconds (1..9)
TIME_LIMIT_BCD, 8'h99, BCD race time {tens,ones} at which the race times out

Ports:
clock  input  1  system clock (CLOCK_50 domain)
reset_n  input  1  asynchronous active-low reset
start  input  1  level from user switch; rising edge is the start/restart command
tick_1hz  input  1  single-cycle pulse once per second from the rate divider
time_ones  input  4  current BCD ones digit from the display counter
time_tens  input  4  current BCD tens digit from the display counter
p1_finish  input  1  single-cycle pulse: player 1 crossed the line
p2_finish  input  1  single-cycle pulse: player 2 crossed the line
count_enable  output  1  enable to the display counter
count_clear_n  output  1  active-low synchronous clear to the display counter
countdown_val  output  4  countdown digit for HEX display (0 outside COUNTDOWN)
state  output  3  current FSM state code
winner  output  2  00 none, 01 P1, 10 P2, 11 tie
p1_time  output  8  latched BCD finish time for P1 {tens,ones}
p2_time  output  8  latched BCD finish time for P2 {tens,ones}
done  output  1  high in FINISHED or TIMEOUT

Behaviour:
- Reset (async, reset_n=0): state=IDLE, countdown_val=0, winner=00, p1_time=p2_time=8'h00, done=0, internal start-edge register=0.
- Start edge: start_rise = start & ~start_q; start_q is registered each cycle.
- IDLE: count_clear_n=0, count_enable=0.
  - On start_rise -> COUNTDOWN; countdown_val<=COUNTDOWN_SECS; winner, p1_time and p2_time cleared.
- COUNTDOWN: count_clear_n=0, count_enable=0.
  - Each tick_1hz decrements countdown_val.
  - tick_1hz with countdown_val==1 -> RACING, countdown_val<=0.
  - start_rise ignored.
- RACING: count_clear_n=1; count_enable = tick_1hz (combinational, only in RACING).
  - Finish latch: on pN_finish, if pN has not yet finished, pN_time<={time_tens,time_ones} sampled that cycle and the pN-finished flag is set.
  - Repeat finish pulses from an already-finished player are ignored.
  - Winner: the first finisher sets winner (01 or 10). If both first finishes land in the same cycle, winner=11 and both times are equal. A later finisher never changes winner.
  - When both flags are set (including same cycle) -> FINISHED.
  - Timeout: tick_1hz with {time_tens,time_ones}==TIME_LIMIT_BCD and not both finished -> TIMEOUT. Each unfinished player's time is set to TIME_LIMIT_BCD.
  - Finish pulse in the same cycle as the timeout tick: the finish is processed first with the sampled time. If that completes both players, go to FINISHED, not TIMEOUT.
- FINISHED / TIMEOUT: count_enable=0, count_clear_n=1 (counter holds final value), done=1.
  - All outputs hold; finish pulses are ignored.
  - start_rise -> IDLE.
- Finish pulses in IDLE or COUNTDOWN are ignored (no false start).
- Reset mid-race returns to IDLE immediately; the counter is cleared via count_clear_n=0 from the next state.
- All registered outputs update on posedge clock. count_enable, count_clear_n and done are decoded combinationally from state (plus tick_1hz for count_enable).

Decomposition:
- Shared package race_pkg holds:
  - state encodings: IDLE=0, COUNTDOWN=1, RACING=2, FINISHED=3, TIMEOUT=4
  - winner codes: WIN_NONE, WIN_P1, WIN_P2, WIN_TIE
  - BCD width constant: 8
- One sub-module, rise_detect (registered-previous-value edge detector with async active-low reset), used for start. The same sub-module is reusable for player buttons elsewhere.

Test Plan:
- Reset then start 0->1, three tick_1hz -> countdown_val 3,2,1 then state=RACING, countdown_val=0; count_clear_n goes 0->1 on entering RACING.
- RACING, time=8'h12, p1_finish; later time=8'h15, p2_finish -> winner=01, p1_time=8'h12, p2_time=8'h15, state=FINISHED, done=1, count_enable stays 0 on later ticks.
- RACING, time=8'h07, p1_finish and p2_finish in same cycle -> winner=11, both times 8'h07, FINISHED.
- TIME_LIMIT_BCD=8'h10, only p2 finishes at 8'h04; tick at 8'h10 -> TIMEOUT, winner=10, p2_time=8'h04, p1_time=8'h10.
- p1_finish during COUNTDOWN -> ignored (winner=00 after RACING entry); duplicate p1_finish in RACING -> p1_time unchanged.
- reset_n pulsed low mid-RACING (asynchronously, between clock edges) -> all outputs at reset values immediately; start_rise in FINISHED -> IDLE with count_clear_n=0.
